ascon_perm_ctrl: RTL and testbench

- Round sequencer and state register that sits directly upstream of the Ascon-p round core and consumes its output.
- Accepts a 320-bit state plus a round count over a valid/ready handshake.
- Each cycle it drives the registered state and a round index into the combinational round core, then captures the core's result.
- After the requested rounds it presents the permuted state on a valid/ready output port.

---
 rtl/ascon_perm_ctrl_if.sv | 29 ++
 rtl/ascon_perm_ctrl.sv | 119 +++++++++++
 tb/tb_ascon_perm_ctrl.sv | 385 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_perm_ctrl_if.sv
// Request, result and round-core signals of ascon_perm_ctrl.
// slave = controller side; master = requester / round-core side.
interface ascon_perm_ctrl_if;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [3:0]  rounds_i;
  logic [63:0] x0_i, x1_i, x2_i, x3_i, x4_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        err_o;
  logic [63:0] x0_o, x1_o, x2_o, x3_o, x4_o;
  logic [3:0]  core_round_cnt_o;
  logic [63:0] core_x0_o, core_x1_o, core_x2_o, core_x3_o, core_x4_o;
  logic [63:0] core_x0_i, core_x1_i, core_x2_i, core_x3_i, core_x4_i;

  modport slave (
    input  in_valid_i, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready_i,
    input  core_x0_i, core_x1_i, core_x2_i, core_x3_i, core_x4_i,
    output in_ready_o, out_valid_o, err_o, x0_o, x1_o, x2_o, x3_o, x4_o,
    output core_round_cnt_o, core_x0_o, core_x1_o, core_x2_o, core_x3_o, core_x4_o
  );

  modport master (
    output in_valid_i, rounds_i, x0_i, x1_i, x2_i, x3_i, x4_i, out_ready_i,
    output core_x0_i, core_x1_i, core_x2_i, core_x3_i, core_x4_i,
    input  in_ready_o, out_valid_o, err_o, x0_o, x1_o, x2_o, x3_o, x4_o,
    input  core_round_cnt_o, core_x0_o, core_x1_o, core_x2_o, core_x3_o, core_x4_o
  );
endinterface

// File: rtl/ascon_perm_ctrl.sv
// Ascon-p round sequencer: holds the 320-bit state and steps an external round core UROL rounds per clock.
// Optional macro ASCON_PERM_ZEROIZE_EN clears state and error flag on the output handshake.
module ascon_perm_ctrl #(
  parameter int UROL = 1
) (
  input logic              clk_i,
  input logic              rst_i,
  ascon_perm_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} stateT;

  localparam logic [3:0] STEP = 4'(UROL);
  localparam logic [3:0] LAST = 4'd12;

  stateT            r_state;
  stateT            w_nextState;
  logic [4:0][63:0] r_x;
  logic [3:0]       r_cnt;
  logic             r_err;

  logic [4:0][63:0] w_xIn;
  logic [4:0][63:0] w_core;
  logic [3:0]       w_cntNext;
  logic             w_lastStep;
  logic             w_legal;

  assign w_xIn      = {bus.x4_i, bus.x3_i, bus.x2_i, bus.x1_i, bus.x0_i};
  assign w_core     = {bus.core_x4_i, bus.core_x3_i, bus.core_x2_i, bus.core_x1_i, bus.core_x0_i};
  assign w_cntNext  = r_cnt + STEP;
  assign w_lastStep = (w_cntNext == LAST);

  // With two rounds per clock an odd count could never land exactly on round 12.
  assign w_legal = (bus.rounds_i != 4'd0) && (bus.rounds_i <= LAST) &&
                   ((UROL == 1) || !bus.rounds_i[0]);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState     = r_state;
    bus.in_ready_o  = 1'b0;
    bus.out_valid_o = 1'b0;
    case (r_state)
      IDLE: begin
        bus.in_ready_o = 1'b1;
        if (bus.in_valid_i) begin
          w_nextState = w_legal ? RUN : DONE;
        end
      end
      RUN: begin
        if (w_lastStep) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        bus.out_valid_o = 1'b1;
        if (bus.out_ready_i) begin
          w_nextState = IDLE;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  // The counter holds the absolute round index so the core can derive its round constants.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_x   <= '0;
      r_cnt <= 4'd0;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid_i) begin
            r_x   <= w_xIn;
            r_err <= !w_legal;
            if (w_legal) begin
              r_cnt <= LAST - bus.rounds_i;
            end
          end
        end
        RUN: begin
          r_x   <= w_core;
          r_cnt <= w_cntNext;
        end
        default: begin
`ifdef ASCON_PERM_ZEROIZE_EN
          if (bus.out_ready_i) begin
            r_x   <= '0;
            r_err <= 1'b0;
          end
`else
          r_err <= r_err;
`endif
        end
      endcase
    end
  end

  assign bus.x0_o             = r_x[0];
  assign bus.x1_o             = r_x[1];
  assign bus.x2_o             = r_x[2];
  assign bus.x3_o             = r_x[3];
  assign bus.x4_o             = r_x[4];
  assign bus.core_x0_o        = r_x[0];
  assign bus.core_x1_o        = r_x[1];
  assign bus.core_x2_o        = r_x[2];
  assign bus.core_x3_o        = r_x[3];
  assign bus.core_x4_o        = r_x[4];
  assign bus.core_round_cnt_o = r_cnt;
  assign bus.err_o            = r_err;

endmodule

// File: tb/tb_ascon_perm_ctrl.sv
// Scoreboard bench for ascon_perm_ctrl: instance A runs UROL=1, instance B runs UROL=2,
// both driven by a behavioural Ascon-p model; ASCON_PERM_ZEROIZE_EN selects the idle-output expectation.
`timescale 1ns/1ps
module tb_ascon_perm_ctrl;

  typedef logic [4:0][63:0] stateT;
  typedef struct {
    stateT x;
    logic  err;
    int    doneCyc;
  } expT;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  logic       inValid   [2];
  logic [3:0] roundsIn  [2];
  stateT      xIn       [2];
  logic       outReady  [2];
  int         readyMode [2];
  stateT      coreIn    [2];
  stateT      coreOut   [2];
  stateT      xOut      [2];
  logic       inReady   [2];
  logic       outValid  [2];
  logic       errOut    [2];
  logic [3:0] coreCnt   [2];

  expT   qA[$];
  expT   qB[$];
  logic  seen     [2];
  logic  postFire [2];
  stateT lastX    [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] ror(input logic [63:0] v, input int n);
    return (v >> n) | (v << (64 - n));
  endfunction

  // One Ascon-p round with round index r of the 12-round schedule.
  function automatic stateT ascRound(input stateT s, input int r);
    logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
    x0 = s[0]; x1 = s[1]; x2 = s[2]; x3 = s[3]; x4 = s[4];
    x2 = x2 ^ 64'((((15 - r) & 15) << 4) | (r & 15));
    x0 = x0 ^ x4; x4 = x4 ^ x3; x2 = x2 ^ x1;
    t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
    x0 = x0 ^ t1; x1 = x1 ^ t2; x2 = x2 ^ t3; x3 = x3 ^ t4; x4 = x4 ^ t0;
    x1 = x1 ^ x0; x0 = x0 ^ x4; x3 = x3 ^ x2; x2 = ~x2;
    x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
    x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
    x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
    x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
    x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
    return {x4, x3, x2, x1, x0};
  endfunction

  function automatic stateT ascRounds(input stateT s, input int first, input int n);
    stateT t;
    t = s;
    for (int i = 0; i < n; i++) t = ascRound(t, first + i);
    return t;
  endfunction

  function automatic stateT randState();
    return {{$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
            {$urandom, $urandom}, {$urandom, $urandom}};
  endfunction

  function automatic logic [3:0] pickRounds(input int k);
    if ($urandom_range(0, 4) == 0) return 4'($urandom_range(0, 15));
    if (k == 0) return 4'($urandom_range(1, 12));
    return 4'(2 * $urandom_range(1, 6));
  endfunction

  ascon_perm_ctrl_if busA ();
  ascon_perm_ctrl_if busB ();

  ascon_perm_ctrl #(.UROL(1)) dutA (.clk_i(clk), .rst_i(rst), .bus(busA));
  ascon_perm_ctrl #(.UROL(2)) dutB (.clk_i(clk), .rst_i(rst), .bus(busB));

  assign busA.in_valid_i  = inValid[0];
  assign busA.rounds_i    = roundsIn[0];
  assign busA.x0_i        = xIn[0][0];
  assign busA.x1_i        = xIn[0][1];
  assign busA.x2_i        = xIn[0][2];
  assign busA.x3_i        = xIn[0][3];
  assign busA.x4_i        = xIn[0][4];
  assign busA.out_ready_i = outReady[0];
  assign busA.core_x0_i   = coreIn[0][0];
  assign busA.core_x1_i   = coreIn[0][1];
  assign busA.core_x2_i   = coreIn[0][2];
  assign busA.core_x3_i   = coreIn[0][3];
  assign busA.core_x4_i   = coreIn[0][4];
  assign inReady[0]  = busA.in_ready_o;
  assign outValid[0] = busA.out_valid_o;
  assign errOut[0]   = busA.err_o;
  assign coreCnt[0]  = busA.core_round_cnt_o;
  assign xOut[0]     = {busA.x4_o, busA.x3_o, busA.x2_o, busA.x1_o, busA.x0_o};
  assign coreOut[0]  = {busA.core_x4_o, busA.core_x3_o, busA.core_x2_o, busA.core_x1_o, busA.core_x0_o};

  assign busB.in_valid_i  = inValid[1];
  assign busB.rounds_i    = roundsIn[1];
  assign busB.x0_i        = xIn[1][0];
  assign busB.x1_i        = xIn[1][1];
  assign busB.x2_i        = xIn[1][2];
  assign busB.x3_i        = xIn[1][3];
  assign busB.x4_i        = xIn[1][4];
  assign busB.out_ready_i = outReady[1];
  assign busB.core_x0_i   = coreIn[1][0];
  assign busB.core_x1_i   = coreIn[1][1];
  assign busB.core_x2_i   = coreIn[1][2];
  assign busB.core_x3_i   = coreIn[1][3];
  assign busB.core_x4_i   = coreIn[1][4];
  assign inReady[1]  = busB.in_ready_o;
  assign outValid[1] = busB.out_valid_o;
  assign errOut[1]   = busB.err_o;
  assign coreCnt[1]  = busB.core_round_cnt_o;
  assign xOut[1]     = {busB.x4_o, busB.x3_o, busB.x2_o, busB.x1_o, busB.x0_o};
  assign coreOut[1]  = {busB.core_x4_o, busB.core_x3_o, busB.core_x2_o, busB.core_x1_o, busB.core_x0_o};

  // Behavioural round core: UROL rounds starting at the index the controller presents.
  assign coreIn[0] = ascRounds(coreOut[0], int'(coreCnt[0]), 1);
  assign coreIn[1] = ascRounds(coreOut[1], int'(coreCnt[1]), 2);

  task automatic checkOutput(input string name, input logic [319:0] act, input logic [319:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic int qSize(input int k);
    if (k == 0) return qA.size();
    return qB.size();
  endfunction

  task automatic qPush(input int k, input expT e);
    if (k == 0) qA.push_back(e);
    else qB.push_back(e);
  endtask

  task automatic qFront(input int k, output expT e);
    if (k == 0) e = qA[0];
    else e = qB[0];
  endtask

  task automatic qPop(input int k);
    expT d;
    if (k == 0) d = qA.pop_front();
    else d = qB.pop_front();
  endtask

  task automatic qFlush(input int k);
    if (k == 0) qA.delete();
    else qB.delete();
  endtask

  // Issues one request, predicts the result, and follows the round index while it runs.
  // abortAt >= 0 pulses reset during that run cycle and discards the prediction.
  task automatic applyStimulus(input int k, input logic [3:0] r, input stateT x, input int abortAt);
    expT   e;
    int    urol;
    int    n;
    int    waitCnt;
    bit    legal;
    string tag;
    urol = k + 1;
    tag = (k == 0) ? "A" : "B";
    inValid[k] = 1'b1;
    roundsIn[k] = r;
    xIn[k] = x;
    waitCnt = 0;
    @(negedge clk);
    while (!inReady[k]) begin
      waitCnt++;
      if (waitCnt > 300) begin
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s accept timeout: in_ready_o got 0, expected 1", tag);
        inValid[k] = 1'b0;
        return;
      end
      @(negedge clk);
    end
    legal = (r >= 4'd1) && (r <= 4'd12) && ((int'(r) % urol) == 0);
    n = legal ? int'(r) / urol : 0;
    e.x = legal ? ascRounds(x, 12 - int'(r), int'(r)) : x;
    e.err = !legal;
    e.doneCyc = cyc + 1 + n;
    qPush(k, e);
    @(posedge clk);
    #2;
    inValid[k] = 1'b0;
    xIn[k] = randState();
    roundsIn[k] = 4'($urandom_range(0, 15));
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      checkOutput($sformatf("%s round index r=%0d step %0d", tag, r, j), 320'(coreCnt[k]),
                  320'(12 - int'(r) + j * urol));
      checkOutput($sformatf("%s out_valid during run", tag), 320'(outValid[k]), 320'(0));
      if (j == abortAt) begin
        #1 rst = 1'b1;
        #1;
        checkOutput({tag, " async reset out_valid"}, 320'(outValid[k]), 320'(0));
        checkOutput({tag, " async reset in_ready"}, 320'(inReady[k]), 320'(1));
        checkOutput({tag, " async reset state"}, xOut[k], 320'(0));
        checkOutput({tag, " async reset round index"}, 320'(coreCnt[k]), 320'(0));
        qFlush(k);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #2;
  endtask

  task automatic waitDrain(input int k);
    int waitCnt;
    waitCnt = 0;
    while (qSize(k) != 0 && waitCnt < 500) begin
      @(negedge clk);
      waitCnt++;
    end
    if (qSize(k) != 0) begin
      vectors++;
      miscompares++;
      $display("[TB] FAIL drain %0d: got %0d results outstanding, expected 0", k, qSize(k));
    end
    @(posedge clk);
    #2;
  endtask

  // Consumer backpressure: random, held low, or held high per instance.
  initial begin
    outReady = '{1'b0, 1'b0};
    forever begin
      @(posedge clk);
      #2;
      for (int k = 0; k < 2; k++) begin
        case (readyMode[k])
          0:       outReady[k] = ($urandom_range(0, 2) != 0);
          1:       outReady[k] = 1'b0;
          default: outReady[k] = 1'b1;
        endcase
      end
    end
  end

  // Monitor: compares every presented result against the head of the scoreboard.
  initial begin : monitor
    string tag;
    expT   e;
    seen = '{1'b0, 1'b0};
    postFire = '{1'b0, 1'b0};
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = '{1'b0, 1'b0};
        postFire = '{1'b0, 1'b0};
      end else begin
        for (int k = 0; k < 2; k++) begin
          tag = (k == 0) ? "A" : "B";
          if (postFire[k]) begin
            checkOutput({tag, " in_ready after handshake"}, 320'(inReady[k]), 320'(1));
`ifdef ASCON_PERM_ZEROIZE_EN
            checkOutput({tag, " zeroized state in idle"}, xOut[k], 320'(0));
            checkOutput({tag, " zeroized err in idle"}, 320'(errOut[k]), 320'(0));
`else
            checkOutput({tag, " retained state in idle"}, xOut[k], lastX[k]);
`endif
            postFire[k] = 1'b0;
          end
          if (outValid[k]) begin
            if (qSize(k) == 0) begin
              vectors++;
              miscompares++;
              $display("[TB] FAIL %s spurious result: got out_valid 1, expected 0", tag);
            end else begin
              qFront(k, e);
              if (!seen[k]) begin
                checkOutput({tag, " latency cycle"}, 320'(cyc), 320'(e.doneCyc));
                seen[k] = 1'b1;
              end
              checkOutput({tag, " result state"}, xOut[k], e.x);
              checkOutput({tag, " err"}, 320'(errOut[k]), 320'(e.err));
              checkOutput({tag, " in_ready while done"}, 320'(inReady[k]), 320'(0));
              if (outReady[k]) begin
                qPop(k);
                seen[k] = 1'b0;
                postFire[k] = 1'b1;
                lastX[k] = e.x;
              end
            end
          end
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation got stuck, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    inValid = '{1'b0, 1'b0};
    roundsIn = '{4'd0, 4'd0};
    xIn = '{'0, '0};
    readyMode = '{0, 0};
    #1 rst = 1'b1;
    #2;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("reset in_ready %0d", k), 320'(inReady[k]), 320'(1));
      checkOutput($sformatf("reset out_valid %0d", k), 320'(outValid[k]), 320'(0));
      checkOutput($sformatf("reset err %0d", k), 320'(errOut[k]), 320'(0));
      checkOutput($sformatf("reset round index %0d", k), 320'(coreCnt[k]), 320'(0));
      checkOutput($sformatf("reset state %0d", k), xOut[k], 320'(0));
    end
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #2;

    $display("[TB] directed requests");
    applyStimulus(0, 4'd12, '0, -1);
    applyStimulus(0, 4'd6, randState(), -1);
    applyStimulus(1, 4'd8, randState(), -1);
    applyStimulus(1, 4'd7, randState(), -1);
    applyStimulus(1, 4'd0, randState(), -1);
    applyStimulus(0, 4'd13, randState(), -1);
    applyStimulus(1, 4'd12, randState(), -1);
    applyStimulus(0, 4'd15, randState(), -1);
    applyStimulus(0, 4'd1, randState(), -1);
    applyStimulus(1, 4'd2, randState(), -1);
    waitDrain(0);
    waitDrain(1);

    $display("[TB] backpressure with ignored requests");
    readyMode[0] = 1;
    applyStimulus(0, 4'd12, randState(), -1);
    for (int i = 0; i < 10; i++) begin
      inValid[0] = (i % 2 == 0);
      xIn[0] = randState();
      roundsIn[0] = 4'd12;
      @(posedge clk);
      #2;
    end
    inValid[0] = 1'b0;
    readyMode[0] = 2;
    waitDrain(0);
    readyMode[0] = 0;

    $display("[TB] reset during run");
    waitDrain(1);
    applyStimulus(0, 4'd12, randState(), 3);
    applyStimulus(0, 4'd12, randState(), -1);
    waitDrain(0);

    $display("[TB] randomized requests");
    fork
      begin
        for (int i = 0; i < 25; i++) applyStimulus(0, pickRounds(0), randState(), -1);
      end
      begin
        for (int i = 0; i < 25; i++) applyStimulus(1, pickRounds(1), randState(), -1);
      end
    join
    waitDrain(0);
    waitDrain(1);
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
